stack_op_sequencer: RTL and testbench

//  Command-level controller for the dual 8-bit stack pair (stack instances ADDR=0/1).
//  It accepts one opcode at a time over a valid/ready handshake and expands it into

---
 rtl/stack_op_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_stack_op_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_op_sequencer.sv
// Command sequencer for the dual 8-bit stack pair: expands one opcode into select/push/pop cycles.
// Optional statistics counters are enabled by defining STACK_SEQ_STATS_EN.
module stack_op_sequencer #(
    parameter int DATA_W = 8,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic              cmd_tgt,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [1:0]        rsp_code,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              stk_sel,
    output logic              stk_push,
    output logic              stk_pop,
    output logic [DATA_W-1:0] stk_din,
    input  logic [DATA_W-1:0] stk_dout,
    input  logic [1:0]        stk_empty,
    input  logic [1:0]        stk_full
`ifdef STACK_SEQ_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_ops,
    output logic [STAT_W-1:0] stat_errs
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRIME, S_POPA, S_RDB, S_PUSH, S_RESTORE, S_RESP
    } state_t;

    typedef logic [STAT_W-1:0] stat_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_DUP  = 3'd3;
    localparam logic [2:0] OP_SWAP = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd6;
    localparam logic [2:0] OP_MOVE = 3'd7;

    localparam logic [1:0] CODE_UNF = 2'b01;
    localparam logic [1:0] CODE_OVF = 2'b10;

    state_t            state;
    logic [2:0]        op_q;
    logic              tgt_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [1:0]        code_q;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] push_data;

    // Arithmetic wraps modulo 2^DATA_W; B is the word below the popped A.
    function automatic logic [DATA_W-1:0] alu(input logic sub,
                                              input logic [DATA_W-1:0] b,
                                              input logic [DATA_W-1:0] a);
        return sub ? (b - a) : (b + a);
    endfunction

    assign alu_res   = alu(op_q == OP_SUB, stk_dout, a_q);
    assign push_data = (op_q == OP_PUSH) ? imm_q : ((op_q == OP_SWAP) ? b_q : a_q);
    assign busy      = ~cmd_ready;

    // Strobes depend on the live empty flag in POPA/RDB, so they are decoded from state.
    always_comb begin
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_din  = '0;
        if (rst_n) begin
            case (state)
                S_POPA: stk_pop = !stk_empty[tgt_q] && (op_q != OP_DUP);
                S_RDB: begin
                    if (!stk_empty[tgt_q]) begin
                        stk_push = 1'b1;
                        stk_pop  = 1'b1;
                        stk_din  = (op_q == OP_SWAP) ? a_q : alu_res;
                    end
                end
                S_PUSH: begin
                    stk_push = 1'b1;
                    stk_din  = push_data;
                end
                S_RESTORE: begin
                    stk_push = 1'b1;
                    stk_din  = a_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_code  <= 2'b00;
            rsp_data  <= '0;
            stk_sel   <= 1'b0;
            op_q      <= OP_NOP;
            tgt_q     <= 1'b0;
            imm_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            code_q    <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= cmd_op;
                        tgt_q     <= cmd_tgt;
                        imm_q     <= cmd_imm;
                        cmd_ready <= 1'b0;
                        if (cmd_op == OP_NOP) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state   <= S_PRIME;
                            stk_sel <= cmd_tgt;
                        end
                    end
                end
                S_PRIME: begin
                    if (op_q != OP_PUSH) begin
                        state <= S_POPA;
                    end else if (stk_full[tgt_q]) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_code  <= CODE_OVF;
                    end else begin
                        state <= S_PUSH;
                    end
                end
                S_POPA: begin
                    a_q <= stk_dout;
                    if (stk_empty[tgt_q]) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_code  <= CODE_UNF;
                    end else begin
                        case (op_q)
                            OP_POP: begin
                                state     <= S_RESP;
                                rsp_valid <= 1'b1;
                                rsp_data  <= stk_dout;
                            end
                            OP_DUP: begin
                                if (stk_full[tgt_q]) begin
                                    state     <= S_RESP;
                                    rsp_valid <= 1'b1;
                                    rsp_err   <= 1'b1;
                                    rsp_code  <= CODE_OVF;
                                end else begin
                                    state <= S_PUSH;
                                end
                            end
                            OP_MOVE: begin
                                if (stk_full[~tgt_q]) begin
                                    state  <= S_RESTORE;
                                    code_q <= CODE_OVF;
                                end else begin
                                    state   <= S_PUSH;
                                    stk_sel <= ~tgt_q;
                                end
                            end
                            default: state <= S_RDB;
                        endcase
                    end
                end
                S_RDB: begin
                    b_q <= stk_dout;
                    if (stk_empty[tgt_q]) begin
                        state  <= S_RESTORE;
                        code_q <= CODE_UNF;
                    end else if (op_q == OP_SWAP) begin
                        state <= S_PUSH;
                    end else begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= alu_res;
                    end
                end
                S_PUSH: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    stk_sel   <= tgt_q;
                end
                S_RESTORE: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_code  <= code_q;
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_code  <= 2'b00;
                    rsp_data  <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef STACK_SEQ_STATS_EN
    function automatic stat_t sat_inc(input stat_t v);
        return (&v) ? v : (v + stat_t'(1));
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_ops  <= '0;
            stat_errs <= '0;
        end else if (rsp_valid) begin
            stat_ops <= sat_inc(stat_ops);
            if (rsp_err) begin
                stat_errs <= sat_inc(stat_errs);
            end
        end
    end
`endif

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer: behavioural dual-stack model plus a directed vector table.
// Stats checks are included when STACK_SEQ_STATS_EN is defined.
module tb_stack_op_sequencer;

    localparam int WORDS = 4;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic       cmd_tgt;
    logic [7:0] cmd_imm;
    logic       rsp_valid;
    logic       rsp_err;
    logic [1:0] rsp_code;
    logic [7:0] rsp_data;
    logic       busy;
    logic       stk_sel;
    logic       stk_push;
    logic       stk_pop;
    logic [7:0] stk_din;
    logic [7:0] stk_dout;
    logic [1:0] stk_empty;
    logic [1:0] stk_full;
`ifdef STACK_SEQ_STATS_EN
    logic [15:0] stat_ops;
    logic [15:0] stat_errs;
`endif

    stack_op_sequencer #(.DATA_W(8), .STAT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_tgt(cmd_tgt), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_code(rsp_code), .rsp_data(rsp_data),
        .busy(busy), .stk_sel(stk_sel), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_din(stk_din), .stk_dout(stk_dout), .stk_empty(stk_empty), .stk_full(stk_full)
`ifdef STACK_SEQ_STATS_EN
        , .stat_ops(stat_ops), .stat_errs(stat_errs)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two stacks; data_out registers the selected stack's top, so it is valid only
    // when the select was stable over the previous cycle.
    int         cnt [2];
    logic [7:0] mem [2][WORDS];
    logic [7:0] dq  [2];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= 0;
                dq[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (stk_sel != 1'(i)) begin
                    dq[i] <= '0;
                end else if (stk_push && stk_pop) begin
                    if (cnt[i] > 0) begin
                        mem[i][cnt[i]-1] <= stk_din;
                        dq[i] <= stk_din;
                    end else begin
                        dq[i] <= '0;
                    end
                end else if (stk_push) begin
                    if (cnt[i] < WORDS) begin
                        mem[i][cnt[i]] <= stk_din;
                        cnt[i] <= cnt[i] + 1;
                        dq[i]  <= stk_din;
                    end else begin
                        dq[i] <= mem[i][WORDS-1];
                    end
                end else if (stk_pop) begin
                    if (cnt[i] > 0) begin
                        cnt[i] <= cnt[i] - 1;
                        dq[i]  <= (cnt[i] > 1) ? mem[i][cnt[i]-2] : 8'h00;
                    end else begin
                        dq[i] <= '0;
                    end
                end else begin
                    dq[i] <= (cnt[i] > 0) ? mem[i][cnt[i]-1] : 8'h00;
                end
            end
        end
    end

    assign stk_dout  = dq[0] | dq[1];
    assign stk_empty = {cnt[1] == 0, cnt[0] == 0};
    assign stk_full  = {cnt[1] == WORDS, cnt[0] == WORDS};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic tgt, input logic [7:0] imm,
                           output logic err, output logic [1:0] code, output logic [7:0] data,
                           output int lat, output int stb);
        int w;
        w = 0;
        err = 1'b0; code = 2'b00; data = 8'h00; lat = 0; stb = 0;
        @(negedge clk);
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("cmd_ready_before_offer", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_tgt = tgt; cmd_imm = imm;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_imm = 8'h00;
        lat = 1;
        chk("busy_after_accept", 32'(busy), 32'd1);
        if (stk_push || stk_pop) stb++;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (stk_push || stk_pop) stb++;
        end
        if (rsp_valid) begin
            err = rsp_err; code = rsp_code; data = rsp_data;
        end else begin
            total++;
            bad++;
            $display("FAIL rsp_timeout: op=%0d got no rsp_valid within %0d cycles", op, lat);
        end
    endtask

    typedef struct {
        logic [2:0] op;
        logic       tgt;
        logic [7:0] imm;
        logic       err;
        logic [1:0] code;
        logic [7:0] data;
        int         lat;
        int         stb;
        int         d0;
        int         d1;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic [2:0] op, input logic tgt, input logic [7:0] imm,
                                input logic err, input logic [1:0] code, input logic [7:0] data,
                                input int lat, input int stb, input int d0, input int d1);
        vec_t v;
        v.op = op; v.tgt = tgt; v.imm = imm; v.err = err; v.code = code; v.data = data;
        v.lat = lat; v.stb = stb; v.d0 = d0; v.d1 = d1;
        vt.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic       e;
        logic [1:0] c;
        logic [7:0] d;
        int         l, s, rv;

        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_tgt = 1'b0; cmd_imm = 8'h00;
        rst_n = 1'b0;

        //   op tgt imm    err code   data   lat stb d0 d1
        add(1, 0, 8'h11, 0, 2'b00, 8'h00, 3, 1, 1, 0);
        add(1, 0, 8'h22, 0, 2'b00, 8'h00, 3, 1, 2, 0);
        add(2, 0, 8'h00, 0, 2'b00, 8'h22, 3, 1, 1, 0);
        add(2, 0, 8'h00, 0, 2'b00, 8'h11, 3, 1, 0, 0);
        add(1, 0, 8'h05, 0, 2'b00, 8'h00, 3, 1, 1, 0);
        add(1, 0, 8'h03, 0, 2'b00, 8'h00, 3, 1, 2, 0);
        add(6, 0, 8'h00, 0, 2'b00, 8'h02, 4, 2, 1, 0);
        add(1, 0, 8'hFF, 0, 2'b00, 8'h00, 3, 1, 2, 0);
        add(5, 0, 8'h00, 0, 2'b00, 8'h01, 4, 2, 1, 0);
        add(2, 0, 8'h00, 0, 2'b00, 8'h01, 3, 1, 0, 0);
        add(1, 1, 8'hAA, 0, 2'b00, 8'h00, 3, 1, 0, 1);
        add(1, 1, 8'hBB, 0, 2'b00, 8'h00, 3, 1, 0, 2);
        add(4, 1, 8'h00, 0, 2'b00, 8'h00, 5, 3, 0, 2);
        add(2, 1, 8'h00, 0, 2'b00, 8'hAA, 3, 1, 0, 1);
        add(2, 1, 8'h00, 0, 2'b00, 8'hBB, 3, 1, 0, 0);
        add(1, 0, 8'h07, 0, 2'b00, 8'h00, 3, 1, 1, 0);
        add(5, 0, 8'h00, 1, 2'b01, 8'h00, 5, 2, 1, 0);
        add(2, 0, 8'h00, 0, 2'b00, 8'h07, 3, 1, 0, 0);
        add(2, 0, 8'h00, 1, 2'b01, 8'h00, 3, 0, 0, 0);
        add(1, 0, 8'h3C, 0, 2'b00, 8'h00, 3, 1, 1, 0);
        add(3, 0, 8'h00, 0, 2'b00, 8'h00, 4, 1, 2, 0);
        add(2, 0, 8'h00, 0, 2'b00, 8'h3C, 3, 1, 1, 0);
        add(2, 0, 8'h00, 0, 2'b00, 8'h3C, 3, 1, 0, 0);
        add(0, 0, 8'h00, 0, 2'b00, 8'h00, 1, 0, 0, 0);
        add(1, 0, 8'h09, 0, 2'b00, 8'h00, 3, 1, 1, 0);
        add(7, 0, 8'h00, 0, 2'b00, 8'h00, 4, 2, 0, 1);
        add(2, 1, 8'h00, 0, 2'b00, 8'h09, 3, 1, 0, 0);
        add(1, 1, 8'h01, 0, 2'b00, 8'h00, 3, 1, 0, 1);
        add(1, 1, 8'h02, 0, 2'b00, 8'h00, 3, 1, 0, 2);
        add(1, 1, 8'h03, 0, 2'b00, 8'h00, 3, 1, 0, 3);
        add(1, 1, 8'h04, 0, 2'b00, 8'h00, 3, 1, 0, 4);
        add(1, 0, 8'h09, 0, 2'b00, 8'h00, 3, 1, 1, 4);
        add(7, 0, 8'h00, 1, 2'b10, 8'h00, 4, 2, 1, 4);
        add(2, 1, 8'h00, 0, 2'b00, 8'h04, 3, 1, 1, 3);
        add(1, 1, 8'h04, 0, 2'b00, 8'h00, 3, 1, 1, 4);
        add(1, 1, 8'h55, 1, 2'b10, 8'h00, 2, 0, 1, 4);
        add(3, 1, 8'h00, 1, 2'b10, 8'h00, 3, 0, 1, 4);
        add(2, 0, 8'h00, 0, 2'b00, 8'h09, 3, 1, 0, 4);

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_word",  {21'd0, rsp_err, rsp_code, rsp_data}, 32'd0);
        chk("rst_stk_bus",   {21'd0, stk_sel, stk_push, stk_pop, stk_din}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            run_cmd(vt[i].op, vt[i].tgt, vt[i].imm, e, c, d, l, s);
            chk($sformatf("v%0d_err", i),  32'(e), 32'(vt[i].err));
            chk($sformatf("v%0d_code", i), 32'(c), 32'(vt[i].code));
            chk($sformatf("v%0d_data", i), 32'(d), 32'(vt[i].data));
            chk($sformatf("v%0d_lat", i),  32'(l), 32'(vt[i].lat));
            chk($sformatf("v%0d_stb", i),  32'(s), 32'(vt[i].stb));
            chk($sformatf("v%0d_d0", i),   32'(cnt[0]), 32'(vt[i].d0));
            chk($sformatf("v%0d_d1", i),   32'(cnt[1]), 32'(vt[i].d1));
        end

        // Reset during SWAP's RDB cycle.
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_cmd(3'd1, 1'b0, 8'h01, e, c, d, l, s);
        run_cmd(3'd1, 1'b0, 8'h02, e, c, d, l, s);
        chk("pre_swap_depth", 32'(cnt[0]), 32'd2);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_tgt = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'd0;
        repeat (2) @(negedge clk);
        chk("swap_rdb_replace", {30'd0, stk_push, stk_pop}, 32'd3);
        chk("swap_rdb_din", 32'(stk_din), 32'h02);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_busy",      32'(busy),      32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_rsp_word",  {21'd0, rsp_err, rsp_code, rsp_data}, 32'd0);
        chk("midrst_stk_bus",   {21'd0, stk_sel, stk_push, stk_pop, stk_din}, 32'd0);
        chk("midrst_depth0",    32'(cnt[0]), 32'd0);
        rv = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) rv++;
        end
        chk("midrst_no_rsp", 32'(rv), 32'd0);

`ifdef STACK_SEQ_STATS_EN
        chk("stat_ops_reset",  32'(stat_ops),  32'd0);
        chk("stat_errs_reset", 32'(stat_errs), 32'd0);
        run_cmd(3'd1, 1'b0, 8'h31, e, c, d, l, s);
        run_cmd(3'd1, 1'b0, 8'h32, e, c, d, l, s);
        run_cmd(3'd2, 1'b0, 8'h00, e, c, d, l, s);
        run_cmd(3'd2, 1'b1, 8'h00, e, c, d, l, s);
        chk("stat_err_op_code", 32'(c), 32'd1);
        @(negedge clk);
        chk("stat_ops",  32'(stat_ops),  32'd4);
        chk("stat_errs", 32'(stat_errs), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
